ddr_port_arbiter: RTL
=====================

Name: ddr_port_arbiter

Overview:
- Shares the single host DDR port (ddr_if.to_host side) between NUM_PORTS requesters, e.g. rom_loader, ddr_rom_loader_adaptor, and later video or sample fetchers.
- Each requester uses the existing acquire/busy ownership protocol; the arbiter grants exclusive ownership round-robin and routes the owner's commands to the host.
- It tracks outstanding read beats and write-burst beats, so ownership never changes mid-transaction.

Parameters:
NUM_PORTS, 2, number of requester ports (2..4)
PEND_W, 10, width of outstanding-read-beat counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_acquire  in  NUM_PORTS  per-port ownership request
req_read  in  NUM_PORTS  per-port read strobe
req_write  in  NUM_PORTS  per-port write strobe
req_addr  in  NUM_PORTS*32  per-port byte address
req_wdata  in  NUM_PORTS*64  per-port write data
req_byteenable  in  NUM_PORTS*8  per-port byte enables
req_burstcnt  in  NUM_PORTS*8  per-port burst length
req_busy  out  NUM_PORTS  per-port busy
req_rdata  out  64  read data, broadcast to all ports
req_rdata_ready  out  NUM_PORTS  per-port read data valid
host_acquire  out  1  to host ddr acquire
host_read  out  1  to host read
host_write  out  1  to host write
host_addr  out  32  to host address
host_wdata  out  64  to host write data
host_byteenable  out  8  to host byte enables
host_burstcnt  out  8  to host burst count
host_busy  in  1  from host busy
host_rdata  in  64  from host read data
host_rdata_ready  in  1  from host read data valid
owner_valid  out  1  debug: a port currently owns the host
owner_idx  out  2  debug: index of owning port

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high.
- States: IDLE, OWNED, DRAIN.
- Reset values:
  - state=IDLE; owner_valid=0; owner_idx=0.
  - last_grant=NUM_PORTS-1, so port 0 wins the first arbitration.
  - pend_rd=0; wr_left=0.
  - All host_* outputs 0.
  - req_busy all 1; req_rdata_ready all 0.
- IDLE:
  - If any req_acquire is set, grant the first set bit searching from last_grant+1 with modulo wrap.
  - Next cycle: owner_idx=winner, owner_valid=1, last_grant=winner, state=OWNED.
  - Grant latency is 1 cycle from acquire to owner_valid.
- Host signal routing is combinational from the owner:
  - host_acquire = owner_valid.
  - host_read, host_write, host_addr, host_wdata, host_byteenable, host_burstcnt are muxed from owner_idx, gated by owner_valid.
  - With no owner: host_read=0, host_write=0, other host_* fields 0.
- Busy and read-data routing:
  - req_busy[owner] = host_busy.
  - req_busy for every non-owner = 1.
  - req_rdata = host_rdata, broadcast to all ports.
  - req_rdata_ready[owner] = host_rdata_ready; 0 for all other ports.
- Non-owner read/write strobes are ignored and never reach the host.
- Read beat tracking:
  - An accepted read (host_read & ~host_busy) adds host_burstcnt to pend_rd.
  - Each host_rdata_ready subtracts 1.
  - Same-cycle accept and return: pend_rd += burstcnt-1.
  - Requesters must keep outstanding beats below 2^PEND_W. Overflow is undefined, but pend_rd must never wrap below 0: a stray rdata_ready with pend_rd=0 leaves it at 0.
- Write beat tracking:
  - First accepted write beat (host_write & ~host_busy & wr_left==0) loads wr_left=burstcnt-1.
  - Each later accepted beat decrements wr_left.
  - burstcnt=1 leaves wr_left at 0.
- OWNED -> DRAIN when req_acquire[owner]=0.
- DRAIN:
  - Host routing stays with the owner, so host_rdata_ready still reaches it.
  - Owner strobes are still routed, but a requester that has dropped acquire must not issue new ones.
  - If req_acquire[owner] returns to 1 before release, go back to OWNED with no re-arbitration.
  - When pend_rd==0 and wr_left==0 and host_busy==0: owner_valid=0, state=IDLE.
  - Release can happen in the same cycle acquire drops (OWNED passes straight to IDLE) if all three conditions already hold.
- Minimum handoff gap: one IDLE cycle with host_acquire=0 between owners.
- Requests do not preempt: a requester holding acquire keeps ownership indefinitely.
- Reset mid-transaction: all state returns to reset values immediately; the host must be reset alongside.

Test Plan:
1. Single requester: port0 acquire at cycle 0 -> owner_valid=1, owner_idx=0 at cycle 1; read addr 0x30000000, burstcnt=1 -> host_read mirrors it; one rdata_ready -> req_rdata_ready=2'b01; drop acquire -> IDLE next cycle.
2. Simultaneous acquire from ports 0 and 1 after reset -> port0 granted first. Port0 releases -> one idle cycle, then port1 granted. Both assert again -> port0 wins (round-robin from last_grant=1).
3. Read drain: port0 issues burstcnt=4, drops acquire after accept, host returns 4 beats at 3-cycle spacing -> owner stays 0 until the 4th rdata_ready, release next cycle, port1 (waiting) granted one cycle later.
4. Write burst: burstcnt=3 with host_busy stalls of 2 cycles between beats -> wr_left 2,1,0; release blocked until wr_left=0; host_write never asserted for non-owner port1 although req_write[1]=1.
5. Non-owner isolation: port1 asserts acquire and read while port0 owns -> req_busy[1]=1, host_read reflects only port0, req_rdata_ready[1]=0 throughout.
6. Reset asserted during DRAIN with pend_rd=2 -> next cycle owner_valid=0, pend_rd=0, host_acquire=0, req_busy=all 1s; port1 acquire afterwards granted in 1 cycle.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Round-robin owner arbiter that shares the single host DDR port among NUM_PORTS requesters.
// Ownership is held until the owner drops acquire and all of its read beats and write beats have completed.
module ddr_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PEND_W    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_acquire,
    input  logic [NUM_PORTS-1:0]   req_read,
    input  logic [NUM_PORTS-1:0]   req_write,
    input  logic [NUM_PORTS*32-1:0] req_addr,
    input  logic [NUM_PORTS*64-1:0] req_wdata,
    input  logic [NUM_PORTS*8-1:0] req_byteenable,
    input  logic [NUM_PORTS*8-1:0] req_burstcnt,
    output logic [NUM_PORTS-1:0]   req_busy,
    output logic [63:0]            req_rdata,
    output logic [NUM_PORTS-1:0]   req_rdata_ready,
    output logic                   host_acquire,
    output logic                   host_read,
    output logic                   host_write,
    output logic [31:0]            host_addr,
    output logic [63:0]            host_wdata,
    output logic [7:0]             host_byteenable,
    output logic [7:0]             host_burstcnt,
    input  logic                   host_busy,
    input  logic [63:0]            host_rdata,
    input  logic                   host_rdata_ready,
    output logic                   owner_valid,
    output logic [1:0]             owner_idx
);

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           last_grant;
    logic [1:0]           grant_idx;
    logic                 grant_found;
    logic [PEND_W-1:0]    pend_rd;
    logic [PEND_W-1:0]    pend_sum;
    logic [PEND_W-1:0]    pend_next;
    logic [7:0]           wr_left;
    logic [NUM_PORTS-1:0] own_sel;
    logic                 owner_acq;
    logic                 drained;
    logic                 rd_accept;
    logic                 wr_accept;

    always_comb begin
        own_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            own_sel[p] = owner_valid && (owner_idx == 2'(p));
        end
    end

    // Everything the host sees comes from the owning port only; with no owner the bus is all zeros.
    always_comb begin
        host_read       = 1'b0;
        host_write      = 1'b0;
        host_addr       = '0;
        host_wdata      = '0;
        host_byteenable = '0;
        host_burstcnt   = '0;
        owner_acq       = 1'b0;
        req_busy        = '1;
        req_rdata_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (own_sel[p]) begin
                host_read          = req_read[p];
                host_write         = req_write[p];
                host_addr          = req_addr[p*32 +: 32];
                host_wdata         = req_wdata[p*64 +: 64];
                host_byteenable    = req_byteenable[p*8 +: 8];
                host_burstcnt      = req_burstcnt[p*8 +: 8];
                owner_acq          = req_acquire[p];
                req_busy[p]        = host_busy;
                req_rdata_ready[p] = host_rdata_ready;
            end
        end
    end

    assign host_acquire = owner_valid;
    assign req_rdata    = host_rdata;

    // Search order starts just after the previous winner, so the outer loop decides priority.
    always_comb begin
        grant_idx   = last_grant;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!grant_found && req_acquire[p] && (((int'(last_grant) + i) % NUM_PORTS) == p)) begin
                    grant_found = 1'b1;
                    grant_idx   = 2'(p);
                end
            end
        end
    end

    assign rd_accept = host_read & ~host_busy;
    assign wr_accept = host_write & ~host_busy;
    assign drained   = (pend_rd == '0) && (wr_left == '0) && !host_busy;

    // A stray beat with nothing outstanding must not wrap the counter.
    always_comb begin
        pend_sum  = pend_rd + (rd_accept ? PEND_W'(host_burstcnt) : '0);
        pend_next = pend_sum;
        if (host_rdata_ready && (pend_sum != '0)) begin
            pend_next = pend_sum - PEND_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = OWNED;
                end
            end
            OWNED: begin
                if (!owner_acq) begin
                    state_next = drained ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (owner_acq) begin
                    state_next = OWNED;
                end else if (drained) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner_valid <= 1'b0;
            owner_idx   <= '0;
            last_grant  <= 2'(NUM_PORTS - 1);
            pend_rd     <= '0;
            wr_left     <= '0;
        end else begin
            state       <= state_next;
            owner_valid <= (state_next != IDLE);
            if ((state == IDLE) && grant_found) begin
                owner_idx  <= grant_idx;
                last_grant <= grant_idx;
            end
            pend_rd <= pend_next;
            if (wr_accept) begin
                if (wr_left == '0) begin
                    wr_left <= (host_burstcnt == '0) ? 8'd0 : host_burstcnt - 8'd1;
                end else begin
                    wr_left <= wr_left - 8'd1;
                end
            end
        end
    end

endmodule
